// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
//   arbState_e           : arbiter FSM state (IDLE accepts grants, RESP returns read data)
//   PORT_IF / PORT_D     : winner encoding used between mem_arb_pick and mem_arbiter
//   STARVE_LIMIT_DEFAULT : default max consecutive data grants while fetch waits
package mem_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned SC_W   = 2;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 3;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arbState_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
//   ifReq, dReq : raw request lines
//   sc          : starvation counter (consecutive data grants while fetch waited)
//   pickValid   : some requester wins this cycle
//   pickPort    : PORT_IF or PORT_D, meaningful only when pickValid=1
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic            ifReq,
    input  logic            dReq,
    input  logic [SC_W-1:0] sc,
    output logic            pickValid,
    output logic            pickPort
);

    logic fetchStarved;

    // Fetch overrides data only once it has lost STARVE_LIMIT times in a row.
    assign fetchStarved = ifReq && (32'(sc) == 32'(STARVE_LIMIT));

    always_comb begin
        pickValid = 1'b0;
        pickPort  = PORT_IF;
        if (dReq && !fetchStarved) begin
            pickValid = 1'b1;
            pickPort  = PORT_D;
        end else if (ifReq) begin
            pickValid = 1'b1;
            pickPort  = PORT_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-ported synchronous memory.
// At most one access outstanding: a read grant moves to RESP for one cycle while
// the memory returns data; writes complete in the grant cycle.
//   clk, Reset                       : clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt          : fetch request / accept pulse
//   if_rvalid/if_rdata                : fetch read return (rdata holds last value)
//   d_req/d_we/d_addr/d_wdata -> d_gnt: data request / accept pulse
//   d_rvalid/d_rdata                  : data read return (reads only)
//   mem_en/mem_wr/mem_addr/mem_wdata  : memory strobe, driven in the grant cycle
//   mem_rdata                         : memory read data, valid one cycle after strobe
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              Reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [SC_W-1:0] SC_MAX = '1;

    arbState_e         state;
    arbState_e         stateNext;
    logic [SC_W-1:0]   sc;
    logic              pickValid;
    logic              pickPort;
    logic              canGrant;
    logic              readGrant;
    logic [DATA_W-1:0] ifRdataQ;
    logic [DATA_W-1:0] dRdataQ;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .ifReq     (if_req),
        .dReq      (d_req),
        .sc        (sc),
        .pickValid (pickValid),
        .pickPort  (pickPort)
    );

    // Grants only from IDLE, and never while reset is held.
    assign canGrant = (state == IDLE) && !Reset;

    assign if_gnt = canGrant && pickValid && (pickPort == PORT_IF);
    assign d_gnt  = canGrant && pickValid && (pickPort == PORT_D);

    // Fetch is always a read; a data grant reads unless d_we is set.
    assign readGrant = if_gnt || (d_gnt && !d_we);

    // Memory strobe is steered from whichever port won this cycle.
    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_en    = 1'b1;
            mem_wr    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state: RESP lasts exactly one cycle after a read grant.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (readGrant) stateNext = RESP;
            RESP: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Starvation counter: counts data wins while fetch is waiting.
    always_ff @(posedge clk) begin
        if (Reset) begin
            sc <= '0;
        end else if (if_gnt) begin
            sc <= '0;
        end else if (d_gnt && if_req && (sc != SC_MAX)) begin
            sc <= sc + SC_W'(1);
        end
    end

    // Read-return pulses, one cycle after the matching read grant.
    always_ff @(posedge clk) begin
        if (Reset) begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
        end else begin
            if_rvalid <= if_gnt;
            d_rvalid  <= d_gnt && !d_we;
        end
    end

    // Hold registers keep the last returned word once the pulse is gone.
    always_ff @(posedge clk) begin
        if (Reset) begin
            ifRdataQ <= '0;
            dRdataQ  <= '0;
        end else begin
            if (if_rvalid) ifRdataQ <= mem_rdata;
            if (d_rvalid)  dRdataQ  <= mem_rdata;
        end
    end

    // Memory data arrives in the rvalid cycle, so it is passed straight through then.
    assign if_rdata = if_rvalid ? mem_rdata : ifRdataQ;
    assign d_rdata  = d_rvalid  ? mem_rdata : dRdataQ;

endmodule
